// File: rtl/regfile_multiport.sv
// Multi-port integer register file with write bypass, busy scoreboard and post-reset clear sweep.
// x0 has no storage; the sweep zeroes x1..x(NREGS-1) before the file reports ready.
module regfile_multiport #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NUM_READ = 2,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_READ*$clog2(NREGS)-1:0] i_raddr,
    output logic [NUM_READ*XLEN-1:0]        o_rdata,
    output logic [NUM_READ-1:0]             o_busy,
    input  logic                            i_write,
    input  logic [$clog2(NREGS)-1:0]        i_waddr,
    input  logic [XLEN-1:0]                 i_wdata,
    input  logic                            i_reserve,
    input  logic [$clog2(NREGS)-1:0]        i_rsv_addr,
    output logic                            o_ready
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] LastReg = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StRun   = 2'd1
    } state_e;

    state_e          r_state, w_state_d;
    logic [AW-1:0]   r_cnt, w_cnt_d;
    logic [NREGS-1:0] r_busy, w_busy_d;
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic            w_clr_we;
    logic            w_wr_we;
    logic            w_ready;

    assign w_ready = (r_state == StRun);
    assign o_ready = w_ready;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_busy_d  = r_busy;
        w_clr_we  = 1'b0;
        w_wr_we   = 1'b0;
        unique case (r_state)
            StClear: begin
                w_clr_we = 1'b1;
                w_cnt_d  = r_cnt + AW'(1);
                if (r_cnt == LastReg) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_wr_we = i_write && (i_waddr != '0);
                if (w_wr_we) begin
                    w_busy_d[i_waddr] = 1'b0;
                end
                // Reserve is applied after the clear so a new producer wins on a same-address clash.
                if (i_reserve && (i_rsv_addr != '0)) begin
                    w_busy_d[i_rsv_addr] = 1'b1;
                end
            end
            default: w_state_d = StClear;
        endcase
        w_busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StClear;
            r_cnt   <= AW'(1);
            r_busy  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= w_busy_d;
        end
    end

    // Storage needs no reset: the sweep clears it once reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_clr_we) begin
                r_regs[r_cnt] <= '0;
            end else if (w_wr_we) begin
                r_regs[i_waddr] <= i_wdata;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_live;
        logic          w_hit;
        assign w_ra   = i_raddr[p*AW +: AW];
        assign w_live = w_ready && (w_ra != '0);
        assign w_hit  = BYPASS && i_write && (i_waddr == w_ra);
        assign o_rdata[p*XLEN +: XLEN] = !w_live ? '0 : (w_hit ? i_wdata : r_regs[w_ra]);
        assign o_busy[p] = w_live && r_busy[w_ra];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench: default 32x32 2-port file with bypass, plus a 16x64
// 3-port instance without bypass sharing clock and reset.
module tb_regfile_multiport;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instance A: XLEN=32, NREGS=32, NUM_READ=2, BYPASS=1
    logic [9:0]  a_raddr = '0;
    logic [63:0] a_rdata;
    logic [1:0]  a_busy;
    logic        a_write = 1'b0;
    logic [4:0]  a_waddr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_reserve = 1'b0;
    logic [4:0]  a_rsv = '0;
    logic        a_ready;

    // Instance B: XLEN=64, NREGS=16, NUM_READ=3, BYPASS=0
    logic [11:0]  b_raddr = '0;
    logic [191:0] b_rdata;
    logic [2:0]   b_busy;
    logic         b_write = 1'b0;
    logic [3:0]   b_waddr = '0;
    logic [63:0]  b_wdata = '0;
    logic         b_reserve = 1'b0;
    logic [3:0]   b_rsv = '0;
    logic         b_ready;

    int n_checks = 0;
    int n_fail = 0;

    regfile_multiport #(.XLEN(32), .NREGS(32), .NUM_READ(2), .BYPASS(1'b1)) u_dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(a_raddr), .o_rdata(a_rdata),
        .o_busy(a_busy), .i_write(a_write), .i_waddr(a_waddr), .i_wdata(a_wdata),
        .i_reserve(a_reserve), .i_rsv_addr(a_rsv), .o_ready(a_ready)
    );

    regfile_multiport #(.XLEN(64), .NREGS(16), .NUM_READ(3), .BYPASS(1'b0)) u_dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(b_raddr), .o_rdata(b_rdata),
        .o_busy(b_busy), .i_write(b_write), .i_waddr(b_waddr), .i_wdata(b_wdata),
        .i_reserve(b_reserve), .i_rsv_addr(b_rsv), .o_ready(b_ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    // Counts negedge samples with o_ready low, starting at the release point.
    // During the first sweep it also tries to write/reserve x3 on A, which must be ignored.
    task automatic wait_ready(input bit poke, output int ca, output int cb);
        ca = -1;
        cb = -1;
        for (int i = 0; i < 100; i++) begin
            if (poke && i == 4) begin
                a_write = 1'b1; a_waddr = 5'd3; a_wdata = 32'hFFFF_0003;
                a_reserve = 1'b1; a_rsv = 5'd3;
                a_raddr = {5'd3, 5'd3};
            end
            if (poke && i == 10) begin
                #1;
                check_eq("clear_rdata_zero", a_rdata, 64'h0);
                check_eq("clear_busy_zero", {62'h0, a_busy}, 64'h0);
            end
            if (poke && i == 20) begin
                a_write = 1'b0; a_reserve = 1'b0;
            end
            if (a_ready && ca < 0) ca = i;
            if (b_ready && cb < 0) cb = i;
            if (ca >= 0 && cb >= 0) break;
            tick();
        end
    endtask

    int ca, cb;

    initial begin
        repeat (3) tick();
        check_eq("rst_ready", {62'h0, a_ready, b_ready}, 64'h0);
        check_eq("rst_rdata", a_rdata, 64'h0);
        check_eq("rst_busy", {61'h0, b_busy}, 64'h0);

        i_rst_n = 1'b1;
        wait_ready(1'b1, ca, cb);
        check_eq("sweep_len_a", 64'(ca), 64'd31);
        check_eq("sweep_len_b", 64'(cb), 64'd15);

        for (int r = 1; r < 32; r++) begin
            a_raddr = {5'(r), 5'(32 - r)};
            #1;
            check_eq($sformatf("a_zero_x%0d", r), a_rdata, 64'h0);
        end
        a_raddr = {5'd3, 5'd3};
        #1;
        check_eq("clear_ignored_busy", {62'h0, a_busy}, 64'h0);
        for (int r = 1; r < 16; r++) begin
            b_raddr = {4'(r), 4'(r), 4'(r)};
            #1;
            check_eq($sformatf("b_zero_x%0d", r), b_rdata[63:0] | b_rdata[127:64] | b_rdata[191:128], 64'h0);
        end

        // Basic write, read on both ports next cycle.
        tick();
        a_write = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        tick();
        a_write = 1'b0; a_raddr = {5'd5, 5'd5};
        #1;
        check_eq("x5_both_ports", a_rdata, 64'hDEAD_BEEF_DEAD_BEEF);

        // x0 write discarded, also not bypassed.
        tick();
        a_write = 1'b1; a_waddr = 5'd0; a_wdata = 32'h1234; a_raddr = {5'd5, 5'd0};
        #1;
        check_eq("x0_bypass", a_rdata, 64'hDEAD_BEEF_0000_0000);
        tick();
        a_write = 1'b0;
        #1;
        check_eq("x0_after", a_rdata, 64'hDEAD_BEEF_0000_0000);

        // Bypass on A.
        tick();
        a_write = 1'b1; a_waddr = 5'd7; a_wdata = 32'hA5A5_A5A5; a_raddr = {5'd5, 5'd7};
        #1;
        check_eq("a_bypass", a_rdata, 64'hDEAD_BEEF_A5A5_A5A5);
        tick();
        a_write = 1'b0;

        // No bypass on B: old value during the write cycle.
        b_write = 1'b1; b_waddr = 4'd7; b_wdata = 64'h1111;
        tick();
        b_wdata = 64'hA5A5_A5A5_A5A5_A5A5; b_raddr = {4'd0, 4'd0, 4'd7};
        #1;
        check_eq("b_no_bypass", b_rdata[63:0], 64'h1111);
        tick();
        b_write = 1'b0;
        #1;
        check_eq("b_after_write", b_rdata[63:0], 64'hA5A5_A5A5_A5A5_A5A5);

        // Scoreboard on A.
        a_reserve = 1'b1; a_rsv = 5'd3; a_raddr = {5'd4, 5'd3};
        #1;
        check_eq("busy_not_bypassed", {62'h0, a_busy}, 64'h0);
        tick();
        a_reserve = 1'b0;
        #1;
        check_eq("busy_set", {62'h0, a_busy}, 64'h1);
        a_write = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
        #1;
        check_eq("busy_hold_during_write", {62'h0, a_busy}, 64'h1);
        tick();
        a_write = 1'b0;
        #1;
        check_eq("busy_cleared", {62'h0, a_busy}, 64'h0);
        check_eq("x3_data", {32'h0, a_rdata[31:0]}, 64'h33);
        a_write = 1'b1; a_wdata = 32'h44; a_reserve = 1'b1; a_rsv = 5'd3;
        tick();
        a_write = 1'b0; a_reserve = 1'b0;
        #1;
        check_eq("rsv_wr_same_busy", {62'h0, a_busy}, 64'h1);
        check_eq("rsv_wr_same_data", {32'h0, a_rdata[31:0]}, 64'h44);
        a_write = 1'b1; a_waddr = 5'd3; a_wdata = 32'h55; a_reserve = 1'b1; a_rsv = 5'd4;
        tick();
        a_write = 1'b0; a_reserve = 1'b1; a_rsv = 5'd0;
        #1;
        check_eq("rsv_wr_diff", {62'h0, a_busy}, 64'h2);
        tick();
        a_reserve = 1'b0; a_raddr = {5'd0, 5'd4};
        #1;
        check_eq("x0_never_busy", {62'h0, a_busy}, 64'h1);

        // B: three independent ports and busy.
        b_write = 1'b1; b_waddr = 4'd1; b_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        b_waddr = 4'd2; b_wdata = 64'hFEDC_BA98_7654_3210;
        tick();
        b_waddr = 4'd15; b_wdata = 64'h8000_0000_0000_0001; b_reserve = 1'b1; b_rsv = 4'd2;
        tick();
        b_write = 1'b0; b_reserve = 1'b0; b_raddr = {4'd15, 4'd2, 4'd1};
        #1;
        check_eq("b_port0", b_rdata[63:0], 64'h0123_4567_89AB_CDEF);
        check_eq("b_port1", b_rdata[127:64], 64'hFEDC_BA98_7654_3210);
        check_eq("b_port2", b_rdata[191:128], 64'h8000_0000_0000_0001);
        check_eq("b_busy", {61'h0, b_busy}, 64'h2);

        // Reset mid-run after reserving x9, then mid-sweep at cnt=10.
        a_reserve = 1'b1; a_rsv = 5'd9; a_raddr = {5'd9, 5'd4};
        tick();
        a_reserve = 1'b0;
        #1;
        check_eq("busy_x9", {62'h0, a_busy}, 64'h3);
        i_rst_n = 1'b0;
        tick();
        #1;
        check_eq("midrun_rst_ready", {62'h0, a_ready, b_ready}, 64'h0);
        check_eq("midrun_rst_busy", {61'h0, b_busy, 1'b0} | {62'h0, a_busy}, 64'h0);
        i_rst_n = 1'b1;
        repeat (9) tick();
        check_eq("midsweep_not_ready", {63'h0, a_ready}, 64'h0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        wait_ready(1'b0, ca, cb);
        check_eq("resweep_len_a", 64'(ca), 64'd31);
        check_eq("resweep_len_b", 64'(cb), 64'd15);
        a_raddr = {5'd9, 5'd4};
        #1;
        check_eq("resweep_busy", {62'h0, a_busy}, 64'h0);
        a_raddr = {5'd5, 5'd3};
        #1;
        check_eq("resweep_data", a_rdata, 64'h0);
        b_raddr = {4'd15, 4'd2, 4'd1};
        #1;
        check_eq("b_resweep_data", b_rdata[63:0] | b_rdata[127:64] | b_rdata[191:128], 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
